// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the seven-segment digit scanner.
package seven_seg_pkg;

    localparam int unsigned SEG_NIBBLE_W = 4;
    localparam int unsigned MAX_DIGITS   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    function automatic logic [MAX_DIGITS-1:0] digit_onehot(input logic [2:0] idx);
        logic [MAX_DIGITS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/seven_seg_slot_timer.sv
// Per-digit slot timer: counts 0..DIGIT_CYCLES-1 while running and flags
// the last blanking cycle and the last cycle of the slot.
module seven_seg_slot_timer
    import seven_seg_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 25000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_l,
    input  logic enable,
    input  logic run,
    output logic blank_done,
    output logic slot_done
);

    localparam int unsigned CNT_W = $clog2(DIGIT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_l || !enable || !run) begin
            count <= '0;
        end else if (count == LAST_CNT) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign blank_done = run && (count == BLANK_END);
    assign slot_done  = run && (count == LAST_CNT);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed seven-segment scanner feeding a shared registered decoder.
// Optional LEADING_ZERO_BLANK_EN suppresses leading-zero digits (digit 0 always lit).
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DIGIT_CYCLES = 25000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                               i_Clk,
    input  logic                               i_Rst_L,
    input  logic                               i_Enable,
    input  logic                               i_Load,
    input  logic [SEG_NIBBLE_W*NUM_DIGITS-1:0] i_Value,
    output logic [SEG_NIBBLE_W-1:0]            o_Nibble,
    output logic [NUM_DIGITS-1:0]              o_Digit_En,
    output logic                               o_Frame_Done
);

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned VAL_W = SEG_NIBBLE_W * NUM_DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    scan_state_t             state, state_next;
    logic [VAL_W-1:0]        shadow;
    logic [VAL_W-1:0]        display, display_next;
    logic [IDX_W-1:0]        index, index_next, next_idx;
    logic [SEG_NIBBLE_W-1:0] nibble_next;
    logic [NUM_DIGITS-1:0]   en_next;
    logic                    frame_done_next;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    blank_done, slot_done;

    seven_seg_slot_timer #(
        .DIGIT_CYCLES (DIGIT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .clk        (i_Clk),
        .rst_l      (i_Rst_L),
        .enable     (i_Enable),
        .run        (state != IDLE),
        .blank_done (blank_done),
        .slot_done  (slot_done)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Scan from the top nibble down; a digit stays lit once any nibble at or above it is non-zero.
    always_comb begin
        logic seen;
        seen    = 1'b0;
        lz_mask = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            seen = seen | (display[SEG_NIBBLE_W*(NUM_DIGITS-1-i) +: SEG_NIBBLE_W] != '0);
            lz_mask[NUM_DIGITS-1-i] = seen;
        end
        lz_mask[0] = 1'b1;
    end
`else
    always_comb begin
        lz_mask = '1;
    end
`endif

    always_comb begin
        state_next      = state;
        index_next      = index;
        display_next    = display;
        nibble_next     = o_Nibble;
        en_next         = '0;
        frame_done_next = 1'b0;
        next_idx        = index + 1'b1;

        case (state)
            IDLE: begin
                if (i_Enable) begin
                    state_next   = BLANK;
                    index_next   = '0;
                    display_next = shadow;
                    nibble_next  = shadow[SEG_NIBBLE_W-1:0];
                end
            end

            BLANK: begin
                if (!i_Enable) begin
                    state_next = IDLE;
                    index_next = '0;
                end else if (blank_done) begin
                    state_next = SHOW;
                    en_next    = NUM_DIGITS'(digit_onehot(3'(index))) & lz_mask;
                end
            end

            SHOW: begin
                if (!i_Enable) begin
                    state_next = IDLE;
                    index_next = '0;
                end else if (slot_done) begin
                    state_next = BLANK;
                    if (index == LAST_IDX) begin
                        // Frame boundary: latch the pre-load shadow so a coincident load lands next frame.
                        index_next      = '0;
                        display_next    = shadow;
                        nibble_next     = shadow[SEG_NIBBLE_W-1:0];
                        frame_done_next = 1'b1;
                    end else begin
                        index_next  = next_idx;
                        nibble_next = display[SEG_NIBBLE_W*next_idx +: SEG_NIBBLE_W];
                    end
                end else begin
                    en_next = o_Digit_En;
                end
            end

            default: begin
                state_next = IDLE;
                index_next = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state        <= IDLE;
            shadow       <= '0;
            display      <= '0;
            index        <= '0;
            o_Nibble     <= '0;
            o_Digit_En   <= '0;
            o_Frame_Done <= 1'b0;
        end else begin
            state        <= state_next;
            display      <= display_next;
            index        <= index_next;
            o_Nibble     <= nibble_next;
            o_Digit_En   <= en_next;
            o_Frame_Done <= frame_done_next;
            if (i_Load) begin
                shadow <= i_Value;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: expected digit windows are queued
// by the stimulus and checked by a monitor as each lit window closes.
`timescale 1ns/1ps
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        enable = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  nibble;
    logic [3:0]  digit_en;
    logic        frame_done;
    logic [6:0]  seg;

    int total = 0;
    int bad = 0;
    bit mon_on = 1'b1;

    typedef struct {
        logic [3:0] en;
        logic [3:0] nib;
        int         len;
        int         gap;
        logic       fd;
        int         per;
    } win_t;

    win_t exp_q[$];

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS   (4),
        .DIGIT_CYCLES (8),
        .BLANK_CYCLES (2)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_l),
        .i_Enable     (enable),
        .i_Load       (load),
        .i_Value      (value),
        .o_Nibble     (nibble),
        .o_Digit_En   (digit_en),
        .o_Frame_Done (frame_done)
    );

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    // Model of the shared registered decoder (one-cycle latency)
    always_ff @(posedge clk) seg <= seg_of(nibble);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] en, input logic [3:0] nib, input int len,
                        input int gap, input logic fd, input int per);
        win_t w;
        w.en = en; w.nib = nib; w.len = len; w.gap = gap; w.fd = fd; w.per = per;
        exp_q.push_back(w);
    endtask

    task automatic push_frame(input logic [15:0] v, input int gap0, input int per);
        push(4'b0001, v[3:0],   6, gap0, 1'b0, 0);
        push(4'b0010, v[7:4],   6, 2,    1'b0, 0);
        push(4'b0100, v[11:8],  6, 2,    1'b0, 0);
        push(4'b1000, v[15:12], 6, 2,    1'b1, per);
    endtask

    task automatic wait_fd(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 100);
        if (frame_done !== 1'b1) begin
            total++; bad++;
            $display("FAIL timeout_%s: got no frame_done expected pulse within 100 cycles", name);
        end
    endtask

    task automatic wait_en(input logic [3:0] target, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (digit_en !== target && n < 100);
        if (digit_en !== target) begin
            total++; bad++;
            $display("FAIL timeout_%s: got en=%b expected %b within 100 cycles", name, digit_en, target);
        end
    endtask

    // Monitor: samples 3ns after each rising edge and checks every closed window
    initial begin : monitor
        logic       in_win;
        logic [3:0] w_en, w_nib;
        int         w_len, w_gap, dark, cyc, last_fd;
        logic       w_ok;
        win_t       e;
        in_win = 1'b0; w_en = '0; w_nib = '0; w_len = 0; w_gap = 0;
        dark = 0; cyc = 0; last_fd = 0; w_ok = 1'b1;
        forever begin
            @(posedge clk);
            #3;
            cyc++;
            if (!rst_l) begin
                dark   = 0;
                in_win = 1'b0;
            end else if (mon_on) begin
                if (digit_en == 4'b0000) begin
                    if (in_win) begin
                        in_win = 1'b0;
                        if (exp_q.size() == 0) begin
                            total++; bad++;
                            $display("FAIL spurious_window: got en=%b expected no window", w_en);
                        end else begin
                            e = exp_q.pop_front();
                            check("win_en", w_en, e.en);
                            check("win_nibble", w_nib, e.nib);
                            check("win_len", w_len, e.len);
                            check("win_gap", w_gap, e.gap);
                            check("win_frame_done", frame_done, e.fd);
                            check("win_seg_stable", w_ok, 1);
                            if (frame_done === 1'b1 && e.per != 0)
                                check("frame_period", cyc - last_fd, e.per);
                        end
                        if (frame_done === 1'b1) last_fd = cyc;
                        dark = 1;
                    end else begin
                        dark++;
                        if (frame_done !== 1'b0) begin
                            total++; bad++;
                            $display("FAIL stray_frame_done: got %b expected 0", frame_done);
                        end
                    end
                end else begin
                    if (!in_win) begin
                        in_win = 1'b1;
                        w_en   = digit_en;
                        w_nib  = nibble;
                        w_len  = 1;
                        w_gap  = dark;
                        w_ok   = 1'b1;
                    end else begin
                        w_len++;
                        if (digit_en !== w_en || nibble !== w_nib) w_ok = 1'b0;
                    end
                    if (seg !== seg_of(w_nib)) w_ok = 1'b0;
                    if (frame_done !== 1'b0) begin
                        total++; bad++;
                        $display("FAIL lit_frame_done: got %b expected 0", frame_done);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        // Load during reset must be ignored; shadow clears to zero
        rst_l = 1'b0; enable = 1'b1; load = 1'b1; value = 16'hFFFF;
        repeat (3) @(posedge clk);
        #3;
        check("rst_nibble", nibble, 0);
        check("rst_digit_en", digit_en, 0);
        check("rst_frame_done", frame_done, 0);

        // Load coincident with scan start: frame 0 shows old shadow (0), frame 1 shows 1A3F
        @(negedge clk);
        rst_l = 1'b1; load = 1'b1; value = 16'h1A3F;
        push_frame(16'h0000, 2, 0);
        push_frame(16'h1A3F, 2, 32);
        @(negedge clk);
        load = 1'b0;
        wait_fd("f0_end");

        // Mid-frame load at index 2: rest of frame 1 unchanged, frame 2 all 5s
        wait_en(4'b0100, "f1_idx2");
        load = 1'b1; value = 16'h5555;
        push_frame(16'h5555, 2, 32);
        @(negedge clk);
        load = 1'b0;
        wait_fd("f1_end");

        // Load on the last SHOW cycle of frame 2: frame 3 still 5s, frame 4 shows C0B2
        wait_en(4'b1000, "f2_idx3");
        repeat (5) @(negedge clk);
        load = 1'b1; value = 16'hC0B2;
        push_frame(16'h5555, 2, 32);
        push(4'b0001, 4'h2, 6, 2, 1'b0, 0);
        push(4'b0010, 4'hB, 6, 2, 1'b0, 0);
        push(4'b0100, 4'h0, 3, 2, 1'b0, 0);
        @(negedge clk);
        load = 1'b0;
        wait_fd("f3_end");

        // Drop enable after 3 lit cycles of index 2, then restart from index 0
        wait_en(4'b0100, "f4_idx2");
        repeat (2) @(negedge clk);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        push_frame(16'hC0B2, 6, 0);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        enable = 1'b0;
        repeat (12) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("idle_digit_en", digit_en, 0);
        mon_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
